// File: rtl/irq_timer_port.sv
// Bus responder generating the CPU irq/nmi lines: 16-bit down-counter, sticky
// interrupt status, a direct level port and a configurable wait-state handshake.
module irq_timer_port #(
  parameter logic [19:0] BASE_ADDR   = 20'h0bff8,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_o_next,
  output logic [7:0]  data_out,
  output logic        sel,
  output logic        ready_out,
  output logic        irq,
  output logic        nmi
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

  localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_RLD_LO = 3'd2;
  localparam logic [2:0] OFF_RLD_HI = 3'd3;
  localparam logic [2:0] OFF_PORT   = 3'd4;
  localparam logic [2:0] OFF_CNT_LO = 3'd5;
  localparam logic [2:0] OFF_CNT_HI = 3'd6;

  state_t      state, state_n;
  logic [2:0]  wcnt, wcnt_n;
  logic        commit;

  logic        ten, ien, arl;
  logic        irqp, nmip;
  logic [7:0]  rld_lo, rld_hi, port_reg;
  logic [15:0] count;
  logic [7:0]  rd_data;

  logic [2:0]  offset;
  logic        wr_en, rd_en, expire;

  assign sel    = (address_next[19:3] == BASE_ADDR[19:3]);
  assign offset = address_next[2:0];

  // Moore-style ready: the cycle that first presents the address is still IDLE,
  // so the stall covers exactly the WAIT cycles of the CPU's own bus cycle.
  assign ready_out = !((state == S_WAIT) && sel);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sel) begin
          if (WAIT_STATES == 0) begin
            commit = 1'b1;
          end else begin
            state_n = S_WAIT;
            wcnt_n  = WCNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!sel)              state_n = S_IDLE;
        else if (wcnt == 3'd0) state_n = S_ACCEPT;
        else                   wcnt_n  = wcnt - 3'd1;
      end
      S_ACCEPT: begin
        commit  = sel;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  assign wr_en  = commit &  write_next;
  assign rd_en  = commit & ~write_next;
  assign expire = ten && (count == 16'd0);

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFF_CTRL:   rd_data = {5'b0, arl, ien, ten};
      OFF_STATUS: rd_data = {6'b0, nmip, irqp};
      OFF_RLD_LO: rd_data = rld_lo;
      OFF_RLD_HI: rd_data = rld_hi;
      OFF_PORT:   rd_data = port_reg;
      OFF_CNT_LO: rd_data = count[7:0];
      OFF_CNT_HI: rd_data = count[15:8];
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ten      <= 1'b0;
      ien      <= 1'b0;
      arl      <= 1'b0;
      irqp     <= 1'b0;
      nmip     <= 1'b0;
      rld_lo   <= 8'h00;
      rld_hi   <= 8'h00;
      port_reg <= 8'h00;
      count    <= 16'h0000;
      data_out <= 8'h00;
      irq      <= 1'b0;
      nmi      <= 1'b0;
    end else begin
      // Sets take priority over write-1-to-clear on the same edge.
      if (expire)
        irqp <= 1'b1;
      else if (wr_en && offset == OFF_STATUS && data_o_next[0])
        irqp <= 1'b0;

      if (wr_en && offset == OFF_CTRL && data_o_next[3])
        nmip <= 1'b1;
      else if (wr_en && offset == OFF_STATUS && data_o_next[1])
        nmip <= 1'b0;

      if (wr_en && offset == OFF_CTRL) begin
        ten <= data_o_next[0];
        ien <= data_o_next[1];
        arl <= data_o_next[2];
      end else if (expire && !arl) begin
        ten <= 1'b0;
      end

      // An RLD_HI write preloads the counter and overrides the timer step.
      if (wr_en && offset == OFF_RLD_HI)
        count <= {data_o_next, rld_lo};
      else if (expire && arl)
        count <= {rld_hi, rld_lo};
      else if (ten && !expire)
        count <= count - 16'd1;

      if (wr_en && offset == OFF_RLD_LO) rld_lo   <= data_o_next;
      if (wr_en && offset == OFF_RLD_HI) rld_hi   <= data_o_next;
      if (wr_en && offset == OFF_PORT)   port_reg <= data_o_next;

      if (rd_en) data_out <= rd_data;

      irq <= (irqp & ien) | port_reg[0];
      nmi <= nmip | port_reg[1];
    end
  end

endmodule

// File: tb/tb_irq_timer_port.sv
// Self-checking bench for irq_timer_port: bus transactions with a read-data
// scoreboard, wait-state timing, timer expiry timing and async reset.
module tb_irq_timer_port;

  localparam logic [19:0] BASE = 20'h0bff8;
  localparam int          WS   = 2;

  logic        clk;
  logic        reset;
  logic [19:0] address_next;
  logic        write_next;
  logic [7:0]  data_o_next;
  logic [7:0]  data_out;
  logic        sel;
  logic        ready_out;
  logic        irq;
  logic        nmi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_commit;
  logic [7:0] exp_q[$];

  irq_timer_port #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .reset        (reset),
    .address_next (address_next),
    .write_next   (write_next),
    .data_o_next  (data_o_next),
    .data_out     (data_out),
    .sel          (sel),
    .ready_out    (ready_out),
    .irq          (irq),
    .nmi          (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the falling edge that follows rising edge number n.
  task automatic at_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Starts just after the next rising edge, checks the stall length and returns
  // just after the commit edge with the bus parked outside the window.
  task automatic bus_access(input logic [19:0] addr, input logic wr, input logic [7:0] wd);
    int lows;
    lows = 0;
    @(posedge clk); #1;
    address_next = addr;
    write_next   = wr;
    data_o_next  = wd;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ready_out) break;
      lows++;
    end
    check("wait_cycles", lows, WS);
    @(posedge clk); #1;
    last_commit  = cyc;
    address_next = 20'h0;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] wd);
    bus_access(BASE + 20'(off), 1'b1, wd);
  endtask

  task automatic bus_read(input string tag, input logic [2:0] off, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus_access(BASE + 20'(off), 1'b0, 8'h00);
    @(negedge clk);
    check(tag, data_out, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, e, nxt;
    reset        = 1'b1;
    address_next = 20'h0;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_ready", ready_out, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_nmi", nmi, 1'b0);
    check("rst_sel", sel, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // PORT holds 5a: bit1 drives nmi, bit0 clear keeps irq low.
    bus_write(3'd4, 8'h5a);
    at_neg(last_commit + 1);
    check("port5a_irq", irq, 1'b0);
    check("port5a_nmi", nmi, 1'b1);
    bus_read("rd_port5a", 3'd4, 8'h5a);

    bus_write(3'd4, 8'h01);
    at_neg(last_commit + 1);
    check("port01_irq", irq, 1'b1);
    check("port01_nmi", nmi, 1'b0);
    bus_write(3'd4, 8'h00);
    at_neg(last_commit + 1);
    check("port00_irq", irq, 1'b0);

    // Offset 7 is a hole: writes vanish and it reads zero.
    bus_write(3'd7, 8'hff);
    bus_read("rd_off7", 3'd7, 8'h00);
    bus_read("rd_port_after7", 3'd4, 8'h00);
    bus_read("rd_ctrl_after7", 3'd0, 8'h00);
    bus_read("rd_rldlo_after7", 3'd2, 8'h00);

    // Just outside the window.
    @(posedge clk); #1;
    address_next = BASE + 20'd8;
    #1;
    check("sel_base8", sel, 1'b0);
    address_next = BASE + 20'd7;
    #1;
    check("sel_base7", sel, 1'b1);
    address_next = BASE + 20'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_base8", ready_out, 1'b1);
    end
    address_next = 20'h0;

    // NMI force via CTRL.NMIF and W1C clear.
    bus_write(3'd0, 8'h08);
    at_neg(last_commit + 1);
    check("nmif_nmi", nmi, 1'b1);
    bus_read("rd_ctrl_nmif", 3'd0, 8'h00);
    bus_read("rd_status_nmip", 3'd1, 8'h02);
    bus_write(3'd1, 8'h02);
    at_neg(last_commit + 1);
    check("nmip_clr_nmi", nmi, 1'b0);

    // One-shot expiry: count 2 -> expires on the 3rd edge, TEN self-clears.
    bus_write(3'd2, 8'h02);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h01);
    bus_read("rd_ctrl_oneshot", 3'd0, 8'h00);
    bus_read("rd_cntlo_oneshot", 3'd5, 8'h00);
    bus_read("rd_cnthi_oneshot", 3'd6, 8'h00);
    bus_read("rd_status_oneshot", 3'd1, 8'h01);
    check("oneshot_irq_masked", irq, 1'b0);
    bus_write(3'd1, 8'h01);
    bus_read("rd_status_clr", 3'd1, 8'h00);

    // Periodic: reload 3 gives an expiry on every 4th edge after CTRL commit.
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h00);
    bus_read("rd_cntlo_load", 3'd5, 8'h03);
    bus_write(3'd0, 8'h07);
    c = last_commit;
    at_neg(c + 4);
    check("per_irq_before", irq, 1'b0);
    at_neg(c + 5);
    check("per_irq_first", irq, 1'b1);
    for (int k = 0; k < 2; k++) begin
      bus_write(3'd1, 8'h01);
      e = last_commit;
      nxt = e;
      while ((nxt - c) % 4 != 0) nxt++;
      at_neg(e + 1);
      check("per_irq_cleared", irq, 1'b0);
      at_neg(nxt);
      check("per_irq_still_low", irq, 1'b0);
      at_neg(nxt + 1);
      check("per_irq_reassert", irq, 1'b1);
    end

    // STATUS clear landing on an expiry edge: the set wins.
    at_neg(c + 23);
    bus_write(3'd1, 8'h01);
    check("sim_edge_aligned", (last_commit - c) % 4, 0);
    at_neg(last_commit + 1);
    check("sim_irq_held1", irq, 1'b1);
    at_neg(last_commit + 2);
    check("sim_irq_held2", irq, 1'b1);
    bus_read("rd_status_sim", 3'd1, 8'h01);
    bus_read("rd_ctrl_periodic", 3'd0, 8'h07);
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    at_neg(last_commit + 1);
    check("stopped_irq", irq, 1'b0);

    // Reset while a read is stalled in WAIT.
    bus_write(3'd4, 8'h03);
    bus_read("rd_port03", 3'd4, 8'h03);
    check("pre_rst_irq", irq, 1'b1);
    check("pre_rst_nmi", nmi, 1'b1);
    @(posedge clk); #1;
    address_next = BASE + 20'd4;
    write_next   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_ready", ready_out, 1'b0);
    reset = 1'b1;
    #1;
    check("midwait_ready", ready_out, 1'b1);
    check("midwait_irq", irq, 1'b0);
    check("midwait_nmi", nmi, 1'b0);
    check("midwait_data", data_out, 8'h00);
    address_next = 20'h0;
    @(negedge clk);
    reset = 1'b0;
    bus_read("rd_port_after_rst", 3'd4, 8'h00);
    bus_read("rd_rldlo_after_rst", 3'd2, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
